// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with single-word lines.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module dcache_wt #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        halted,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]          state_reg;
  logic [1:0]          state_next;
  logic [LINES-1:0]    valid_reg;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [IDX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0] cpu_tag;
  logic [IDX_BITS-1:0] mem_idx;
  logic [TAG_BITS-1:0] mem_tag;
  logic                cpu_line_hit;
  logic                mem_line_hit;
  logic                wr_req;
  logic                rd_req;
  logic                rd_hit;
  logic                rd_miss;
  logic                fill_done;
  logic                write_done;
  logic                addr_unused;

  assign cpu_idx = cpu_addr[IDX_BITS+1:2];
  assign cpu_tag = cpu_addr[31:IDX_BITS+2];
  assign mem_idx = mem_addr[IDX_BITS+1:2];
  assign mem_tag = mem_addr[31:IDX_BITS+2];
  assign addr_unused = ^{cpu_addr[1:0], mem_addr[1:0]};

  assign cpu_line_hit = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign mem_line_hit = valid_reg[mem_idx] && (tag_mem[mem_idx] == mem_tag);

  // A simultaneous load+store is a store; halted masks any new request.
  assign wr_req  = (state_reg == IDLE) && !halted && cpu_wr_en;
  assign rd_req  = (state_reg == IDLE) && !halted && cpu_rd_en && !cpu_wr_en;
  assign rd_hit  = rd_req && cpu_line_hit;
  assign rd_miss = rd_req && !cpu_line_hit;

  assign fill_done  = (state_reg == FILL) && mem_ack;
  assign write_done = (state_reg == WRITE) && mem_ack;

  always_comb begin
    state_next = state_reg;
    cpu_stall  = 1'b0;
    cpu_rdata  = 32'd0;
    if (rst_b) begin
      case (state_reg)
        IDLE: begin
          if (wr_req) begin
            cpu_stall  = 1'b1;
            state_next = WRITE;
          end else if (rd_miss) begin
            cpu_stall  = 1'b1;
            state_next = FILL;
          end else if (rd_hit) begin
            cpu_rdata = data_mem[cpu_idx];
          end
        end
        FILL: begin
          // Fill data is forwarded in the ack cycle so the load retires without an extra cycle.
          if (mem_ack) begin
            cpu_rdata  = mem_rdata;
            state_next = IDLE;
          end else begin
            cpu_stall = 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state_next = IDLE;
          end else begin
            cpu_stall = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && (state_next != IDLE)) begin
        mem_req  <= 1'b1;
        mem_we   <= (state_next == WRITE);
        mem_addr <= {cpu_addr[31:2], 2'b00};
        if (state_next == WRITE) begin
          mem_wdata <= cpu_wdata;
        end
      end else if (fill_done || write_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_reg <= '0;
    end else if (fill_done) begin
      valid_reg[mem_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[mem_idx]  <= mem_tag;
      data_mem[mem_idx] <= mem_rdata;
    end else if (write_done && mem_line_hit) begin
      data_mem[mem_idx] <= mem_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (rd_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (rd_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus randomized traffic
// checked against a line-address reference cache and a word memory model.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        halted;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_wt #(.IDX_BITS(4)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .cpu_rd_en(cpu_rd_en),
    .cpu_wr_en(cpu_wr_en),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .halted(halted),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int ack_delay = 3;
  bit stray_ack = 1'b0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference cache: each line remembers which word address it holds.
  bit          ref_valid [16];
  logic [31:0] ref_line  [16];
  logic [31:0] ref_data  [16];
  logic [31:0] mem_model [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Slow memory: acks ack_delay cycles after mem_req is first seen.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        wait_cnt  = 0;
      end else if (stray_ack) begin
        stray_ack = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end else if (mem_req && rst_b) begin
        wait_cnt++;
        if (wait_cnt > ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_val(mem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Called just after a rising edge with the cache idle; returns just after a rising edge.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] waddr;
    logic [31:0] exp_rdata;
    int idx;
    int stalls;
    int exp_stall;
    bit is_rd;
    bit hit;
    bit exp_req;
    bit saw_req;
    bit done;
    waddr     = {addr[31:2], 2'b00};
    idx       = int'((addr >> 2) & 32'hF);
    is_rd     = rd && !wr;
    hit       = ref_valid[idx] && (ref_line[idx] == waddr);
    exp_req   = wr || (is_rd && !hit);
    exp_stall = exp_req ? 1 + ack_delay : 0;
    exp_rdata = hit ? ref_data[idx] : mem_val(waddr);
    stalls    = 0;
    saw_req   = 1'b0;
    done      = 1'b0;
    cpu_rd_en = rd;
    cpu_wr_en = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req && !saw_req) begin
        saw_req = 1'b1;
        check("mem_we", {31'd0, mem_we}, {31'd0, wr});
        check("mem_addr", mem_addr, waddr);
        if (wr) check("mem_wdata", mem_wdata, wdata);
      end
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    check("timeout", {31'd0, done}, 32'd1);
    check("stall_cycles", stalls, exp_stall);
    check("mem_req_seen", {31'd0, saw_req}, {31'd0, exp_req});
    if (is_rd) check("rdata", cpu_rdata, exp_rdata);
    $display("txn rd=%0b wr=%0b addr=0x%08h wdata=0x%08h stalls=%0d rdata=0x%08h delay=%0d",
             rd, wr, addr, wdata, stalls, cpu_rdata, ack_delay);
    if (is_rd && hit) exp_hits++;
    if (is_rd && !hit) begin
      exp_misses++;
      ref_valid[idx] = 1'b1;
      ref_line[idx]  = waddr;
      ref_data[idx]  = exp_rdata;
    end
    if (wr && hit) ref_data[idx] = wdata;
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst_b     = 1'b0;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    halted    = 1'b0;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Cold read then repeat read
    ack_delay = 3;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    do_access(1, 0, 32'h100, 0);
    do_access(1, 0, 32'h100, 0);
    // Store to cached line, then hit with new data
    do_access(0, 1, 32'h100, 32'h1122_3344);
    check("mem_after_store", mem_val(32'h100), 32'h1122_3344);
    do_access(1, 0, 32'h100, 0);
    // No-write-allocate
    do_access(0, 1, 32'h200, 32'hCAFE_F00D);
    do_access(1, 0, 32'h200, 0);
    // Index conflict
    do_access(1, 0, 32'h040, 0);
    do_access(1, 0, 32'h440, 0);
    do_access(1, 0, 32'h040, 0);
    do_access(1, 0, 32'h100, 0);

    // No request: outputs quiet even when the address would hit
    cpu_addr = 32'h100;
    @(negedge clk);
    check("idle_rdata", cpu_rdata, 32'd0);
    check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a FILL
    ack_delay = 5;
    cpu_rd_en = 1'b1;
    cpu_addr  = 32'h304;
    @(negedge clk);
    check("fill_start_stall", {31'd0, cpu_stall}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fill_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_stall", {31'd0, cpu_stall}, 32'd0);
    cpu_rd_en = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    ack_delay  = 3;
    do_access(1, 0, 32'h100, 0);

    // Read+write together acts as a write; stray ack while idle is harmless
    do_access(1, 1, 32'h100, 32'h5566_7788);
    stray_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("stray_no_req", {31'd0, mem_req}, 32'd0);
    do_access(1, 0, 32'h100, 0);

    // Halted: new requests ignored
    halted    = 1'b1;
    cpu_rd_en = 1'b1;
    cpu_addr  = 32'hF00;
    @(negedge clk);
    check("halt_rd_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    cpu_wr_en = 1'b1;
    @(negedge clk);
    check("halt_req", {31'd0, mem_req}, 32'd0);
    check("halt_wr_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("halt_req2", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    halted    = 1'b0;

    // Randomized traffic over a small address pool so hits, misses and conflicts all occur
    for (int n = 0; n < 300; n++) begin
      ack_delay = $urandom_range(1, 4);
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 6) do_access(1, 0, a, 0);
      else if (op < 9) do_access(0, 1, a, $urandom);
      else do_access(1, 1, a, $urandom);
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("hit_cnt", hit_cnt, exp_hits);
    check("miss_cnt", miss_cnt, exp_misses);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
